// File: rtl/somador_serial_nbits.sv
// Multi-cycle N-bit adder/subtractor: one DIGIT-bit slice per clock, start/busy/done handshake.
// Latency STEPS+1 cycles; start ignored while busy. Optional overflow output via SOMADOR_OVF_EN.
module somador_serial_nbits #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] soma,
`ifdef SOMADOR_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = $clog2(STEPS) + 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SOMA = 2'd1;
   localparam logic [1:0] S_FIM  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] soma_q, soma_d;
   logic             cout_q, cout_d;
`ifdef SOMADOR_OVF_EN
   logic             ovf_q, ovf_d;
   logic             c_msb_in;
`endif

   logic             accept;
   logic [DIGIT-1:0] a_sl, b_sl;
   logic [DIGIT:0]   sum_w;

   assign accept = start && ((state_q == S_IDLE) || (state_q == S_FIM));

   // Shared slice adder; operand slice chosen by the counter with constant part-selects.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int i = 0; i < STEPS; i++) begin
         if (cnt_q == CW'(i)) begin
            a_sl = a_q[i*DIGIT +: DIGIT];
            b_sl = b_q[i*DIGIT +: DIGIT];
         end
      end
      sum_w = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry_q};
   end

`ifdef SOMADOR_OVF_EN
   assign c_msb_in = a_sl[DIGIT-1] ^ b_sl[DIGIT-1] ^ sum_w[DIGIT-1];
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      soma_d  = soma_q;
      cout_d  = cout_q;
`ifdef SOMADOR_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_SOMA: begin
            for (int i = 0; i < STEPS; i++) begin
               if (cnt_q == CW'(i)) begin
                  soma_d[i*DIGIT +: DIGIT] = sum_w[DIGIT-1:0];
               end
            end
            carry_d = sum_w[DIGIT];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cout_d  = sum_w[DIGIT];
`ifdef SOMADOR_OVF_EN
               ovf_d   = c_msb_in ^ sum_w[DIGIT];
`endif
               state_d = S_FIM;
            end
         end
         S_FIM:   state_d = S_IDLE;
         S_IDLE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Subtraction is a + ~b + 1: invert B at capture and force the initial carry.
      if (accept) begin
         a_d     = a;
         b_d     = b ^ {WIDTH{sub}};
         carry_d = sub ? 1'b1 : cin;
         cnt_d   = '0;
         soma_d  = '0;
         state_d = S_SOMA;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         soma_q  <= '0;
         cout_q  <= 1'b0;
`ifdef SOMADOR_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         soma_q  <= soma_d;
         cout_q  <= cout_d;
`ifdef SOMADOR_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == S_SOMA);
   assign done = (state_q == S_FIM);
   assign soma = soma_q;
   assign cout = cout_q;
`ifdef SOMADOR_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_somador_serial_nbits.sv
// Directed bench for somador_serial_nbits: 4-bit bit-serial instance plus an 8-bit, 4-bit-slice instance.
module tb_somador_serial_nbits;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, cout4;
   logic [3:0] soma4;
`ifdef SOMADOR_OVF_EN
   logic       ovf4, ovf8;
`endif

   logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, cout8;
   logic [7:0] soma8;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   somador_serial_nbits #(.WIDTH(4), .DIGIT(1)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
      .busy(busy4), .done(done4), .soma(soma4),
`ifdef SOMADOR_OVF_EN
      .ovf(ovf4),
`endif
      .cout(cout4));

   somador_serial_nbits #(.WIDTH(8), .DIGIT(4)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .busy(busy8), .done(done8), .soma(soma8),
`ifdef SOMADOR_OVF_EN
      .ovf(ovf8),
`endif
      .cout(cout8));

   // Runs one op on dut4; lat = cycles from start cycle to done (-1 on timeout).
   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic s,
                      output logic [3:0] so, output logic co, output int lat, output logic busy_ok);
      @(posedge clk); #1;
      a4 = a; b4 = b; cin4 = c; sub4 = s; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      a4 = ~a; b4 = ~b; cin4 = ~c;
      lat = -1;
      busy_ok = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (done4) begin
            lat = n;
            break;
         end
         if (busy4 !== 1'b1) busy_ok = 1'b0;
      end
      so = soma4;
      co = cout4;
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output logic [7:0] so, output logic co, output int lat);
      @(posedge clk); #1;
      a8 = a; b8 = b; cin8 = c; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (done8) begin
            lat = n;
            break;
         end
      end
      so = soma8;
      co = cout8;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({busy4, done4, cout4, soma4} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset4 got busy=%b done=%b cout=%b soma=%h want all 0", busy4, done4, cout4, soma4);
      end
      n_checks++;
      if ({busy8, done8, cout8, soma8} !== 11'b0) begin
         n_fail++;
         $display("FAIL reset8 got busy=%b done=%b cout=%b soma=%h want all 0", busy8, done8, cout8, soma8);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_exhaustive_add();
      logic [3:0] so;
      logic       co, bok;
      int         lat;
      logic [4:0] exp;
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
               op4(4'(i), 4'(j), 1'(c), 1'b0, so, co, lat, bok);
               exp = 5'(i + j + c);
               n_checks++;
               if ({co, so} !== exp || lat != 5 || !bok) begin
                  n_fail++;
                  $display("FAIL add a=%h b=%h cin=%0d got {cout,soma}=%h lat=%0d busy_ok=%b want %h lat=5",
                           i, j, c, {co, so}, lat, bok, exp);
               end
            end
         end
      end
   endtask

   task automatic test_sub();
      logic [3:0] so;
      logic       co, bok;
      int         lat;
      op4(4'h3, 4'h5, 1'b0, 1'b1, so, co, lat, bok);
      n_checks++;
      if (so !== 4'hE || co !== 1'b0 || lat != 5) begin
         n_fail++;
         $display("FAIL sub_3_5 got soma=%h cout=%b lat=%0d want soma=e cout=0 lat=5", so, co, lat);
      end
      // cin is ignored when subtracting
      op4(4'h5, 4'h3, 1'b1, 1'b1, so, co, lat, bok);
      n_checks++;
      if (so !== 4'h2 || co !== 1'b1 || lat != 5) begin
         n_fail++;
         $display("FAIL sub_5_3 got soma=%h cout=%b lat=%0d want soma=2 cout=1 lat=5", so, co, lat);
      end
      op4(4'h7, 4'h7, 1'b0, 1'b1, so, co, lat, bok);
      n_checks++;
      if (so !== 4'h0 || co !== 1'b1) begin
         n_fail++;
         $display("FAIL sub_7_7 got soma=%h cout=%b want soma=0 cout=1", so, co);
      end
   endtask

   task automatic test_back_to_back();
      int   ndone = 0;
      logic exp_done;
      @(posedge clk); #1;
      a4 = 4'h3; b4 = 4'h4; cin4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
      @(posedge clk); #1;
      a4 = 4'h9;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         exp_done = (n == 5 || n == 10);
         if (done4) ndone++;
         n_checks++;
         if (done4 !== exp_done) begin
            n_fail++;
            $display("FAIL b2b_done cycle=%0d got done=%b want %b", n, done4, exp_done);
         end
         if (n == 5) begin
            n_checks++;
            if (soma4 !== 4'h7 || cout4 !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_op1 got soma=%h cout=%b want soma=7 cout=0", soma4, cout4);
            end
            @(posedge clk); #1;
            start4 = 1'b0;
         end
         if (n == 10) begin
            n_checks++;
            if (soma4 !== 4'hD || cout4 !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_op2 got soma=%h cout=%b want soma=d cout=0", soma4, cout4);
            end
         end
      end
      n_checks++;
      if (ndone != 2) begin
         n_fail++;
         $display("FAIL b2b_count got %0d done pulses want 2", ndone);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [3:0] so;
      logic       co, bok;
      int         lat;
      @(posedge clk); #1;
      a4 = 4'h5; b4 = 4'h2; cin4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (busy4 !== 1'b1 || soma4 !== 4'h1) begin
         n_fail++;
         $display("FAIL mid_op got busy=%b soma=%h want busy=1 soma=1", busy4, soma4);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy4, done4, cout4, soma4} !== 7'b0) begin
         n_fail++;
         $display("FAIL async_rst got busy=%b done=%b cout=%b soma=%h want all 0", busy4, done4, cout4, soma4);
      end
      @(negedge clk);
      rst = 1'b0;
      op4(4'h9, 4'h9, 1'b0, 1'b0, so, co, lat, bok);
      n_checks++;
      if (so !== 4'h2 || co !== 1'b1 || lat != 5) begin
         n_fail++;
         $display("FAIL post_rst got soma=%h cout=%b lat=%0d want soma=2 cout=1 lat=5", so, co, lat);
      end
   endtask

   task automatic test_digit4();
      logic [7:0] so;
      logic       co;
      int         lat;
      op8(8'hFF, 8'h01, 1'b0, so, co, lat);
      n_checks++;
      if (so !== 8'h00 || co !== 1'b1 || lat != 3) begin
         n_fail++;
         $display("FAIL w8_ff_01 got soma=%h cout=%b lat=%0d want soma=00 cout=1 lat=3", so, co, lat);
      end
      op8(8'h3C, 8'h58, 1'b1, so, co, lat);
      n_checks++;
      if (so !== 8'h95 || co !== 1'b0 || lat != 3) begin
         n_fail++;
         $display("FAIL w8_3c_58 got soma=%h cout=%b lat=%0d want soma=95 cout=0 lat=3", so, co, lat);
      end
   endtask

`ifdef SOMADOR_OVF_EN
   task automatic test_ovf();
      logic [3:0] so;
      logic       co, bok;
      int         lat;
      op4(4'h7, 4'h1, 1'b0, 1'b0, so, co, lat, bok);
      n_checks++;
      if (so !== 4'h8 || ovf4 !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_7p1 got soma=%h ovf=%b want soma=8 ovf=1", so, ovf4);
      end
      op4(4'h8, 4'h1, 1'b0, 1'b1, so, co, lat, bok);
      n_checks++;
      if (so !== 4'h7 || ovf4 !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_8m1 got soma=%h ovf=%b want soma=7 ovf=1", so, ovf4);
      end
      op4(4'h2, 4'h3, 1'b0, 1'b0, so, co, lat, bok);
      n_checks++;
      if (so !== 4'h5 || ovf4 !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_2p3 got soma=%h ovf=%b want soma=5 ovf=0", so, ovf4);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_exhaustive_add();
      test_sub();
      test_back_to_back();
      test_reset_mid_op();
      test_digit4();
`ifdef SOMADOR_OVF_EN
      test_ovf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
